// File: rtl/bidi_bus_arbiter_if.sv
// Bundle of the arbiter's request, bus-sample and receive-side signals.
//
// Modports:
//   master - the arbiter: samples req_1/req_2/bus_data, drives enables, rx words, status.
//   slave  - the two bus ends plus transceiver: drive requests and the sampled bus.
//
// Signals:
//   req_1, req_2           side has a word to send this cycle
//   bus_data[N]            sampled value of the shared bus
//   oe_1, oe_2             registered, mutually exclusive transceiver enables
//   rx_data_1/rx_valid_1   word received by side 1 (sent by side 2) and its strobe
//   rx_data_2/rx_valid_2   word received by side 2 (sent by side 1) and its strobe
//   busy                   arbiter not idle
//   xfer_count[16]         total words transferred (zero unless the counter is built)
interface bidi_bus_arbiter_if #(
  parameter int unsigned N = 8
);
  logic         req_1;
  logic         req_2;
  logic [N-1:0] bus_data;
  logic         oe_1;
  logic         oe_2;
  logic [N-1:0] rx_data_1;
  logic         rx_valid_1;
  logic [N-1:0] rx_data_2;
  logic         rx_valid_2;
  logic         busy;
  logic [15:0]  xfer_count;

  modport master (
    input  req_1, req_2, bus_data,
    output oe_1, oe_2, rx_data_1, rx_valid_1, rx_data_2, rx_valid_2, busy, xfer_count
  );

  modport slave (
    output req_1, req_2, bus_data,
    input  oe_1, oe_2, rx_data_1, rx_valid_1, rx_data_2, rx_valid_2, busy, xfer_count
  );
endinterface

// File: rtl/bidi_bus_arbiter.sv
// Direction arbiter for a two-ended shared tristate bus.
//
// Generates mutually exclusive transceiver enables, inserts TURN_CYCLES idle cycles on every
// release of the bus, limits bursts to MAX_BURST words while the other side waits (round robin
// via the last owner), and captures each transferred word for the receiving end with a
// one-cycle valid strobe.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus_io - bidi_bus_arbiter_if.master (requests, bus sample, enables, rx words, status)
//
// Optional feature: define BIDI_ARB_XFER_COUNT_EN to build the 16-bit wrapping transfer
// counter; otherwise xfer_count is tied to zero.
module bidi_bus_arbiter #(
  parameter int unsigned N           = 8,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bidi_bus_arbiter_if.master        bus_io
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrive1 = 2'd1,
    StDrive2 = 2'd2,
    StTurn   = 2'd3
  } state_e;

  // Turn counter is loaded with TURN_CYCLES-1 so the arbitration edge is the last TURN edge.
  localparam logic [3:0] TurnLoad  = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] MaxBurst8 = 8'(MAX_BURST);

  state_e       state_q;
  logic         oe_1_q;
  logic         oe_2_q;
  logic         busy_q;
  logic [1:0]   last_q;
  logic [7:0]   burst_q;
  logic [3:0]   turn_cnt_q;
  logic [N-1:0] rx_data_1_q;
  logic [N-1:0] rx_data_2_q;
  logic         rx_valid_1_q;
  logic         rx_valid_2_q;

  state_e       arb_state;
  logic         own_req;
  logic         other_req;
  logic         xfer_fire;
  logic [7:0]   burst_inc;
  logic         burst_hit;

  always_comb begin
    arb_state = StIdle;
    // Tie goes to the side that did not own the bus last.
    if (bus_io.req_1 && (!bus_io.req_2 || (last_q == 2'd2))) begin
      arb_state = StDrive1;
    end else if (bus_io.req_2) begin
      arb_state = StDrive2;
    end

    own_req   = (state_q == StDrive2) ? bus_io.req_2 : bus_io.req_1;
    other_req = (state_q == StDrive2) ? bus_io.req_1 : bus_io.req_2;
    xfer_fire = ((state_q == StDrive1) || (state_q == StDrive2)) && own_req;
    burst_inc = burst_q + 8'd1;
    burst_hit = (burst_inc == MaxBurst8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      oe_1_q       <= 1'b0;
      oe_2_q       <= 1'b0;
      busy_q       <= 1'b0;
      last_q       <= 2'd2;
      burst_q      <= 8'd0;
      turn_cnt_q   <= 4'd0;
      rx_data_1_q  <= '0;
      rx_data_2_q  <= '0;
      rx_valid_1_q <= 1'b0;
      rx_valid_2_q <= 1'b0;
    end else begin
      rx_valid_1_q <= 1'b0;
      rx_valid_2_q <= 1'b0;

      unique case (state_q)
        StIdle, StTurn: begin
          if ((state_q == StIdle) || (turn_cnt_q == 4'd0)) begin
            state_q <= arb_state;
            oe_1_q  <= (arb_state == StDrive1);
            oe_2_q  <= (arb_state == StDrive2);
            busy_q  <= (arb_state != StIdle);
            burst_q <= 8'd0;
          end else begin
            turn_cnt_q <= turn_cnt_q - 4'd1;
          end
        end

        StDrive1, StDrive2: begin
          if (xfer_fire) begin
            if (state_q == StDrive1) begin
              rx_data_2_q  <= bus_io.bus_data;
              rx_valid_2_q <= 1'b1;
              last_q       <= 2'd1;
            end else begin
              rx_data_1_q  <= bus_io.bus_data;
              rx_valid_1_q <= 1'b1;
              last_q       <= 2'd2;
            end
            if (burst_hit) begin
              burst_q <= 8'd0;
              // Yield only if the other side is actually waiting.
              if (other_req) begin
                state_q    <= StTurn;
                oe_1_q     <= 1'b0;
                oe_2_q     <= 1'b0;
                turn_cnt_q <= TurnLoad;
              end
            end else begin
              burst_q <= burst_inc;
            end
          end else begin
            // Owner released: no capture on this edge.
            state_q    <= StTurn;
            oe_1_q     <= 1'b0;
            oe_2_q     <= 1'b0;
            turn_cnt_q <= TurnLoad;
          end
        end

        default: begin
          state_q <= StIdle;
          oe_1_q  <= 1'b0;
          oe_2_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BIDI_ARB_XFER_COUNT_EN
  logic [15:0] xfer_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= 16'h0000;
    end else if (xfer_fire) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign bus_io.xfer_count = xfer_count_q;
`else
  assign bus_io.xfer_count = 16'h0000;
`endif

  assign bus_io.oe_1       = oe_1_q;
  assign bus_io.oe_2       = oe_2_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.rx_data_1  = rx_data_1_q;
  assign bus_io.rx_valid_1 = rx_valid_1_q;
  assign bus_io.rx_data_2  = rx_data_2_q;
  assign bus_io.rx_valid_2 = rx_valid_2_q;

endmodule

// File: tb/tb_bidi_bus_arbiter.sv
// Self-checking bench for bidi_bus_arbiter: directed scenarios plus random requests, all
// compared each cycle against a behavioural owner/turnaround model.
module tb_bidi_bus_arbiter;
  localparam int unsigned N     = 8;
  localparam int unsigned TURN  = 3;
  localparam int unsigned MB    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bidi_bus_arbiter_if #(.N(N)) bus_if ();

  bidi_bus_arbiter #(
    .N           (N),
    .TURN_CYCLES (TURN),
    .MAX_BURST   (MB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_if)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Model: who owns the bus (0 = nobody), remaining undriven turnaround cycles,
  // words sent in the current burst, and the last side that sent a word.
  int           m_owner;
  int           m_turn;
  int           m_burst;
  int           m_last;
  logic [N-1:0] m_rx1;
  logic [N-1:0] m_rx2;
  logic         m_v1;
  logic         m_v2;
  logic [15:0]  m_xfer;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_turn  = 0;
    m_burst = 0;
    m_last  = 2;
    m_rx1   = '0;
    m_rx2   = '0;
    m_v1    = 1'b0;
    m_v2    = 1'b0;
    m_xfer  = 16'h0;
  endtask

  task automatic model_grant(input logic r1, input logic r2);
    if (r1 && (!r2 || m_last == 2)) m_owner = 1;
    else if (r2) m_owner = 2;
    else m_owner = 0;
    m_burst = 0;
  endtask

  // One rising edge with the given inputs.
  task automatic model_step(input logic r1, input logic r2, input logic [N-1:0] d);
    logic mine, theirs;
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    if (m_turn > 0) begin
      m_turn--;
      if (m_turn == 0) model_grant(r1, r2);
    end else if (m_owner == 0) begin
      model_grant(r1, r2);
    end else begin
      mine   = (m_owner == 1) ? r1 : r2;
      theirs = (m_owner == 1) ? r2 : r1;
      if (mine) begin
        if (m_owner == 1) begin m_rx2 = d; m_v2 = 1'b1; end
        else begin m_rx1 = d; m_v1 = 1'b1; end
        m_last = m_owner;
        m_xfer = m_xfer + 16'd1;
        m_burst++;
        if (m_burst == MB) begin
          m_burst = 0;
          if (theirs) begin
            m_owner = 0;
            m_turn  = TURN;
          end
        end
      end else begin
        m_owner = 0;
        m_turn  = TURN;
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_cnt;
`ifdef BIDI_ARB_XFER_COUNT_EN
    exp_cnt = m_xfer;
`else
    exp_cnt = 16'h0;
`endif
    check_eq("oe_1", bus_if.oe_1, m_owner == 1);
    check_eq("oe_2", bus_if.oe_2, m_owner == 2);
    check_eq("busy", bus_if.busy, (m_owner != 0) || (m_turn > 0));
    check_eq("rx_valid_1", bus_if.rx_valid_1, m_v1);
    check_eq("rx_valid_2", bus_if.rx_valid_2, m_v2);
    check_eq("rx_data_1", bus_if.rx_data_1, m_rx1);
    check_eq("rx_data_2", bus_if.rx_data_2, m_rx2);
    check_eq("xfer_count", bus_if.xfer_count, exp_cnt);
    check_eq("oe_exclusive", bus_if.oe_1 & bus_if.oe_2, 1'b0);
    check_eq("valid_exclusive", bus_if.rx_valid_1 & bus_if.rx_valid_2, 1'b0);
  endtask

  // Called at a falling edge: apply inputs, advance model, check after the next rise.
  task automatic tick(input logic r1, input logic r2, input logic [N-1:0] d);
    bus_if.req_1    = r1;
    bus_if.req_2    = r2;
    bus_if.bus_data = d;
    model_step(r1, r2, d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int pulses;
    int p1, p2;
    logic [7:0] a_word;

    bus_if.req_1    = 1'b0;
    bus_if.req_2    = 1'b0;
    bus_if.bus_data = '0;
    model_reset();

    // Reset hold, then idle with no requests.
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 8'($urandom));

    // Side 1 sends A1..A3 after the grant edge, then releases.
    tick(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      a_word = 8'hA0 + 8'(i);
      tick(1'b1, 1'b0, a_word);
      check_eq("a_seq_data", bus_if.rx_data_2, a_word);
    end
    for (int i = 0; i < TURN + 2; i++) tick(1'b0, 1'b0, 8'h00);
    check_eq("a_seq_idle", bus_if.busy, 1'b0);

    // Long single-sided stream: burst limit never forces a turnaround.
    pulses = 0;
    tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 8'($urandom));
      if (bus_if.rx_valid_2) pulses++;
    end
    check_eq("stream_pulses", 32'(pulses), 32'd20);

    // Side 1 releases while side 2 waits: TURN undriven cycles, then side 2.
    for (int i = 1; i <= TURN + 1; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      check_eq("turn_oe_2", bus_if.oe_2, i == TURN + 1);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < TURN + 2; i++) tick(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-burst on side 1.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h11);
    tick(1'b1, 1'b0, 8'h12);
    bus_if.bus_data = 8'h5C;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_oe_1", bus_if.oe_1, 1'b0);
    check_eq("rst_oe_2", bus_if.oe_2, 1'b0);
    check_eq("rst_rx_valid_2", bus_if.rx_valid_2, 1'b0);
    check_eq("rst_busy", bus_if.busy, 1'b0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Tie after reset goes to side 1, then alternating bursts of MB.
    tick(1'b1, 1'b1, 8'h00);
    check_eq("tie_side1", bus_if.oe_1, 1'b1);
    for (int i = 0; i < 3 * (MB + TURN + 1); i++) tick(1'b1, 1'b1, 8'($urandom));

    // Random traffic with request densities changing every 100 cycles.
    p1 = 50;
    p2 = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 100 == 0) begin
        p1 = int'($urandom_range(10, 98));
        p2 = int'($urandom_range(10, 98));
      end
      tick($urandom_range(0, 99) < p1, $urandom_range(0, 99) < p2, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
